// File: rtl/alu_latch_pkg.sv
// Shared widths, types and bus constants for the ALU result latch.
// Consumed by alu_result_latch and alu_latch_bus_drv.
package alu_latch_pkg;

  localparam int RESULT_W = 16;
  localparam int BYTE_W   = 8;
  localparam int FLAG_W   = 3;

  typedef logic [RESULT_W-1:0] result_t;
  typedef logic [BYTE_W-1:0]   byte_t;
  typedef logic [FLAG_W-1:0]   flags_t;

  // Released bus value: every bit high-impedance.
  localparam byte_t BUS_IDLE = 'z;

  function automatic byte_t hi_byte(input result_t word);
    return word[RESULT_W-1:BYTE_W];
  endfunction

  function automatic byte_t lo_byte(input result_t word);
    return word[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/alu_latch_bus_drv.sv
// Byte selector and tri-state driver for the shared 8-bit data bus.
// High byte has priority over low byte; the bus floats when neither is requested.
module alu_latch_bus_drv
  import alu_latch_pkg::*;
(
  input  logic                enable,
  input  logic                store_high,
  input  logic                store_low,
  input  logic [RESULT_W-1:0] word,
  output logic [BYTE_W-1:0]   data_out
);

  byte_t sel_byte;
  logic  drive;

  always_comb begin
    sel_byte = lo_byte(word);
    if (store_high) sel_byte = hi_byte(word);
  end

  assign drive    = enable & (store_high | store_low);
  assign data_out = drive ? sel_byte : BUS_IDLE;

endmodule

// File: rtl/alu_result_latch.sv
// Holding register between the ALU and the shared data bus: captures result and flags on grab.
// Define ALU_LATCH_BYPASS_EN to forward alu_result to the bus when grab and a store coincide.
module alu_result_latch
  import alu_latch_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                store_high,
  input  logic                store_low,
  input  logic                grab,
  input  logic [RESULT_W-1:0] alu_result,
  input  logic [FLAG_W-1:0]   flags_in,
  output logic [BYTE_W-1:0]   data_out,
  output logic [FLAG_W-1:0]   flags_out
);

  result_t result_q;
  flags_t  flags_q;
  result_t bus_src;

  // Capture stage: one edge from grab to visible result/flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (grab) begin
      result_q <= alu_result;
      flags_q  <= flags_in;
    end
  end

  assign flags_out = flags_q;

`ifdef ALU_LATCH_BYPASS_EN
  assign bus_src = grab ? alu_result : result_q;
`else
  assign bus_src = result_q;
`endif

  // Reset itself gates the driver so the bus floats at once, without a clock.
  alu_latch_bus_drv u_bus_drv (
    .enable     (reset),
    .store_high (store_high),
    .store_low  (store_low),
    .word       (bus_src),
    .data_out   (data_out)
  );

endmodule

// File: tb/tb_alu_result_latch.sv
// Self-checking bench for alu_result_latch: directed scenarios then randomized traffic
// with asynchronous reset pulses, compared against a behavioural reference model.
module tb_alu_result_latch;
  import alu_latch_pkg::*;

  logic        clock      = 1'b0;
  logic        reset      = 1'b0;
  logic        store_high = 1'b0;
  logic        store_low  = 1'b0;
  logic        grab       = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic [2:0]  flags_in   = 3'b000;
  wire  [7:0]  data_bus;
  wire  [2:0]  flags_out;
  wire         bus_z = (data_bus === 8'hzz);

  int checks = 0;
  int errors = 0;

  // Reference state: what the latch should be holding.
  logic [15:0] m_result = 16'h0000;
  logic [2:0]  m_flags  = 3'b000;

  alu_result_latch dut (
    .clock      (clock),
    .reset      (reset),
    .store_high (store_high),
    .store_low  (store_low),
    .grab       (grab),
    .alu_result (alu_result),
    .flags_in   (flags_in),
    .data_out   (data_bus),
    .flags_out  (flags_out)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected bus as {floating, byte}; byte is zero when floating.
  function automatic logic [8:0] exp_bus();
    logic [15:0] src;
    if (!reset || !(store_high || store_low)) return 9'h100;
    src = m_result;
`ifdef ALU_LATCH_BYPASS_EN
    if (grab) src = alu_result;
`endif
    return {1'b0, (store_high ? src[15:8] : src[7:0])};
  endfunction

  task automatic check_outputs(input string tag);
    logic [8:0] obs;
    obs = bus_z ? 9'h100 : {1'b0, data_bus};
    check_val({tag, "_bus"}, {23'd0, obs}, {23'd0, exp_bus()});
    check_val({tag, "_flags"}, {29'd0, flags_out}, {29'd0, (reset ? m_flags : 3'b000)});
  endtask

  // Inputs are already applied; check before and after the next rising edge.
  task automatic step(input string tag);
    #1;
    check_outputs({tag, "_pre"});
    @(posedge clock);
    if (reset && grab) begin
      m_result = alu_result;
      m_flags  = flags_in;
    end
    #1;
    check_outputs({tag, "_post"});
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clock);
    reset    = 1'b0;
    m_result = 16'h0000;
    m_flags  = 3'b000;
    #1;
    check_outputs(tag);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset held with a store request: bus floats, flags clear, no capture.
    store_high = 1'b1;
    grab       = 1'b1;
    alu_result = 16'hABCD;
    flags_in   = 3'b110;
    #2;
    check_outputs("rst_hold");
    step("rst_clk");
    store_high = 1'b0;
    grab       = 1'b0;
    reset      = 1'b1;
    step("rst_rel");

    grab = 1'b1; alu_result = 16'hFEEF; flags_in = 3'b101;
    step("grab1");
    grab = 1'b0; alu_result = 16'hEFFE; flags_in = 3'b111;
    step("hold");
    store_high = 1'b1;               step("st_hi");
    store_high = 1'b0;               step("st_hi_off");
    store_low  = 1'b1;               step("st_lo");
    store_low  = 1'b0;               step("st_lo_off");
    store_high = 1'b1; store_low = 1'b1;
    step("st_both");
    check_val("both_value", {24'd0, data_bus}, 32'h0000_00FE);

    // Asynchronous reset while the bus is driven.
    store_low = 1'b0;
    reset_pulse("rst_async");
    store_high = 1'b0;

    // Grab and store in the same cycle.
    grab = 1'b1; store_low = 1'b1; alu_result = 16'h1234; flags_in = 3'b011;
    step("grab_store");
    grab = 1'b0; store_low = 1'b0; store_high = 1'b1;
    step("after_gs");

    for (int i = 0; i < 400; i++) begin
      grab       = ($urandom_range(0, 2) == 0);
      store_high = ($urandom_range(0, 3) == 0);
      store_low  = ($urandom_range(0, 2) == 0);
      alu_result = 16'($urandom_range(0, 65535));
      flags_in   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) reset_pulse("rnd_rst");
      else step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
